region_read_arbiter: RTL and testbench

Shares the single read port of one replicated region channel (one BRAM/FIFO pair selected by a 2-bit `rfifobram` code) among several compute requesters. It grants one read per cycle using round-robin with bounded burst locking, and routes each returned word back to the requester that issued it. It sits between the pipeline stages and one read channel of the region block.

---
 rtl/region_read_arbiter_if.sv | 34 +++
 rtl/region_read_arbiter.sv | 115 +++++++++++
 tb/tb_region_read_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/region_read_arbiter_if.sv
// Requester and region-channel signals for one shared region read port.
// The slave modport is the arbiter; the master modport is the environment around it.
interface region_read_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int WIDTH          = 8,
    parameter int LOG2_DEPTH     = 5
);
    logic [NUM_REQUESTERS-1:0]                 req_re;
    logic [NUM_REQUESTERS-1:0][LOG2_DEPTH-1:0] req_raddr;
    logic [NUM_REQUESTERS-1:0][1:0]            req_rfifobram;
    logic [NUM_REQUESTERS-1:0]                 req_gnt;
    logic [NUM_REQUESTERS-1:0]                 req_rvalid;
    logic [WIDTH-1:0]                          req_rdata;
    logic                                      region_re;
    logic [LOG2_DEPTH-1:0]                     region_raddr;
    logic [1:0]                                region_rfifobram;
    logic                                      region_rvalid;
    logic [WIDTH-1:0]                          region_rdata;
    logic                                      region_empty;

    modport slave (
        input  req_re, req_raddr, req_rfifobram,
        input  region_rvalid, region_rdata, region_empty,
        output req_gnt, req_rvalid, req_rdata,
        output region_re, region_raddr, region_rfifobram
    );

    modport master (
        output req_re, req_raddr, req_rfifobram,
        output region_rvalid, region_rdata, region_empty,
        input  req_gnt, req_rvalid, req_rdata,
        input  region_re, region_raddr, region_rfifobram
    );
endinterface

// File: rtl/region_read_arbiter.sv
// Round-robin, burst-bounded sharing of one region read port among requesters.
// Latency: grant and region_re combinational in T, return strobe in T+1.
// Backpressure: no grant means wait; a FIFO request is held off while region_empty is 1.
module region_read_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int WIDTH          = 8,
    parameter int LOG2_DEPTH     = 5,
    parameter int MAX_BURST      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    region_read_arbiter_if.slave  bus
);
    localparam int         IDX_W     = $clog2(NUM_REQUESTERS);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    typedef enum logic {IDLE, OWN} state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          owner, owner_nxt, rr_ptr, rr_ptr_nxt, ret_id;
    logic [IDX_W-1:0]          owner_inc, search_base, cand, found_idx, gnt_idx;
    logic [7:0]                burst_cnt, burst_cnt_nxt;
    logic                      ret_pending, keep, found, gnt_any;
    logic [NUM_REQUESTERS-1:0] elig;
    logic [LOG2_DEPTH-1:0]     sel_raddr;
    logic [WIDTH-1:0]          ret_data;

    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            elig[i] = bus.req_re[i] &&
                      ((bus.req_rfifobram[i] == 2'b01) ||
                       ((bus.req_rfifobram[i] == 2'b10) && !bus.region_empty));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            ret_id      <= '0;
            ret_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            burst_cnt   <= burst_cnt_nxt;
            ret_id      <= gnt_idx;
            ret_pending <= gnt_any;
        end
    end

    // Losing ownership re-searches from owner+1 in the same cycle, so switches cost no bubble.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        gnt_any       = 1'b0;
        gnt_idx       = '0;
        found         = 1'b0;
        found_idx     = '0;
        cand          = '0;
        owner_inc     = (owner == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : owner + 1'b1;
        keep          = (state == OWN) && elig[owner] && (burst_cnt < BURST_MAX);
        search_base   = (state == OWN) ? owner_inc : rr_ptr;

        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cand = IDX_W'((int'(search_base) + k) % NUM_REQUESTERS);
            if (!found && elig[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end

        if (keep) begin
            gnt_any       = 1'b1;
            gnt_idx       = owner;
            burst_cnt_nxt = burst_cnt + 8'd1;
        end else begin
            if (state == OWN) rr_ptr_nxt = owner_inc;
            if (found) begin
                gnt_any       = 1'b1;
                gnt_idx       = found_idx;
                state_nxt     = OWN;
                owner_nxt     = found_idx;
                burst_cnt_nxt = 8'd1;
            end else begin
                state_nxt = IDLE;
            end
        end

        if (reset) gnt_any = 1'b0;
    end

    always_comb begin
        bus.req_gnt          = '0;
        bus.req_rvalid       = '0;
        sel_raddr            = '0;
        bus.region_rfifobram = 2'b00;
        if (gnt_any) begin
            bus.req_gnt[gnt_idx] = 1'b1;
            sel_raddr            = bus.req_raddr[gnt_idx];
            bus.region_rfifobram = bus.req_rfifobram[gnt_idx];
        end
        // Data with no read in flight is dropped.
        if (ret_pending && bus.region_rvalid) bus.req_rvalid[ret_id] = 1'b1;
    end

    assign bus.region_re    = gnt_any;
    assign bus.region_raddr = sel_raddr;
    assign ret_data         = bus.region_rdata;
    assign bus.req_rdata    = ret_data;
endmodule

// File: tb/tb_region_read_arbiter.sv
// Directed bench for region_read_arbiter; expected grants and returns are queued
// with the cycle they must appear in, and a negedge monitor pops and compares.
module tb_region_read_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 5;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    region_read_arbiter_if #(.NUM_REQUESTERS(N), .WIDTH(W), .LOG2_DEPTH(AW)) bus ();

    region_read_arbiter #(
        .NUM_REQUESTERS(N), .WIDTH(W), .LOG2_DEPTH(AW), .MAX_BURST(MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    // Region channel: data = 0xA0 + address, valid one cycle after region_re.
    logic         mdl_vld = 1'b0;
    logic         spur    = 1'b0;
    logic [W-1:0] mdl_dat = '0;
    always @(posedge clk) begin
        mdl_vld <= bus.region_re;
        mdl_dat <= 8'hA0 + {3'b000, bus.region_raddr};
    end
    assign bus.region_rvalid = mdl_vld | spur;
    assign bus.region_rdata  = mdl_dat;

    typedef struct {
        int            cyc;
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
        logic [1:0]    rfb;
    } gexp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] vld;
        logic [W-1:0] dat;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_gnt(input int c, input int idx, input logic [AW-1:0] a, input logic [1:0] f);
        gexp_t e;
        e.cyc      = c;
        e.gnt      = '0;
        e.gnt[idx] = 1'b1;
        e.addr     = a;
        e.rfb      = f;
        gq.push_back(e);
    endtask

    task automatic push_ret(input int c, input int idx, input logic [W-1:0] d);
        rexp_t e;
        e.cyc      = c;
        e.vld      = '0;
        e.vld[idx] = 1'b1;
        e.dat      = d;
        rq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gnt"},    32'(bus.req_gnt),          32'd0);
        check({name, "_rvalid"}, 32'(bus.req_rvalid),       32'd0);
        check({name, "_re"},     32'(bus.region_re),        32'd0);
        check({name, "_raddr"},  32'(bus.region_raddr),     32'd0);
        check({name, "_rfb"},    32'(bus.region_rfifobram), 32'd0);
    endtask

    gexp_t mg;
    rexp_t mr;
    logic  hg, hr;

    always @(negedge clk) begin
        hg = (gq.size() > 0) && (gq[0].cyc == cyc);
        if (hg) mg = gq.pop_front();
        else begin
            mg.gnt  = '0;
            mg.addr = '0;
            mg.rfb  = '0;
        end
        if (hg || (bus.req_gnt != '0))
            check("grant", 32'({bus.req_gnt, bus.region_re, bus.region_raddr, bus.region_rfifobram}),
                  32'({mg.gnt, |mg.gnt, mg.addr, mg.rfb}));

        hr = (rq.size() > 0) && (rq[0].cyc == cyc);
        if (hr) begin
            mr = rq.pop_front();
            check("return", 32'({bus.req_rvalid, bus.req_rdata}), 32'({mr.vld, mr.dat}));
        end else if (bus.req_rvalid != '0) begin
            check("unexpected_return", 32'(bus.req_rvalid), 32'd0);
        end
    end

    initial begin
        reset             = 1'b1;
        bus.req_re        = '0;
        bus.req_raddr     = '0;
        bus.req_rfifobram = {N{2'b01}};
        bus.region_empty  = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Single requester, BRAM, three back-to-back reads.
        bus.req_re       = 4'b0100;
        bus.req_raddr[2] = 5'd5;
        push_gnt(cyc, 2, 5'd5, 2'b01);
        push_ret(cyc + 1, 2, 8'hA5);
        step();
        bus.req_raddr[2] = 5'd6;
        push_gnt(cyc, 2, 5'd6, 2'b01);
        push_ret(cyc + 1, 2, 8'hA6);
        step();
        bus.req_raddr[2] = 5'd7;
        push_gnt(cyc, 2, 5'd7, 2'b01);
        push_ret(cyc + 1, 2, 8'hA7);
        step();
        bus.req_re = '0;
        step();
        step();

        // Invalid target codes on req0.
        bus.req_re           = 4'b0001;
        bus.req_rfifobram[0] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.req_rfifobram[0] = 2'b00;
            #1;
            check("invalid_code", 32'({bus.req_gnt[0], bus.region_re}), 32'd0);
            step();
        end
        bus.req_re           = '0;
        bus.req_rfifobram[0] = 2'b01;
        step();

        // FIFO empty: rr_ptr is 3 here, req3 (BRAM) runs its burst, req1 (FIFO) waits.
        bus.region_empty     = 1'b1;
        bus.req_re           = 4'b1010;
        bus.req_rfifobram[1] = 2'b10;
        bus.req_raddr[1]     = 5'd3;
        bus.req_raddr[3]     = 5'd9;
        for (int i = 0; i < 3; i++) begin
            push_gnt(cyc, 3, 5'd9, 2'b01);
            push_ret(cyc + 1, 3, 8'hA9);
            step();
        end
        bus.region_empty = 1'b0;
        push_gnt(cyc, 3, 5'd9, 2'b01);
        push_ret(cyc + 1, 3, 8'hA9);
        step();
        bus.req_re = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            push_gnt(cyc, 1, 5'd3, 2'b10);
            push_ret(cyc + 1, 1, 8'hA3);
            step();
        end
        bus.req_re           = '0;
        bus.req_rfifobram[1] = 2'b01;
        step();
        step();

        // Reset while a return is in flight; then all four request continuously.
        bus.req_re       = 4'b0100;
        bus.req_raddr[2] = 5'd4;
        push_gnt(cyc, 2, 5'd4, 2'b01);
        step();
        reset      = 1'b1;
        bus.req_re = 4'b1111;
        for (int i = 0; i < N; i++) bus.req_raddr[i] = AW'(16 + i);
        #1;
        check_all_zero("reset_in_flight");
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 5 * MB; k++) begin
            int idx;
            idx = (k / MB) % N;
            push_gnt(cyc, idx, AW'(16 + idx), 2'b01);
            push_ret(cyc + 1, idx, W'(8'hB0 + idx));
            step();
        end
        bus.req_re = '0;
        step();
        step();

        // Spurious region_rvalid with nothing in flight.
        spur = 1'b1;
        #1;
        check("spurious_return", 32'(bus.req_rvalid), 32'd0);
        step();
        spur = 1'b0;
        step();
        step();

        check("grants_outstanding",  32'(gq.size()), 32'd0);
        check("returns_outstanding", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
